// File: rtl/pipe_hazard_ctrl_if.sv
// Decode-side bundle between the control unit and pipe_hazard_ctrl.
// The master drives the decoded instruction and flags; the slave returns the pipeline controls.
interface pipe_hazard_ctrl_if #(
  parameter int unsigned IW         = 16,
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
);
  logic [IW-1:0]         instr_in;
  logic                  instr_valid;
  logic [2:0]            flag;
  logic                  pc_hold;
  logic [1:0]            pc_sel;
  logic                  flush;
  logic                  bubble;
  logic                  br_taken;
  logic [HIST_DEPTH-1:0] raw_mask;
  logic [CNT_W-1:0]      stall_cnt;
  logic [CNT_W-1:0]      flush_cnt;

  modport master (
    output instr_in, instr_valid, flag,
    input  pc_hold, pc_sel, flush, bubble, br_taken, raw_mask, stall_cnt, flush_cnt
  );

  modport slave (
    input  instr_in, instr_valid, flag,
    output pc_hold, pc_sel, flush, bubble, br_taken, raw_mask, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard / branch-resolution controller: history shift, RAW mask, redirect FSM, perf counters.
// Define HAZ_LOADUSE_EN to enable load-use bubble insertion.
module pipe_hazard_ctrl #(
  parameter int unsigned IW         = 16,
  parameter int unsigned HIST_DEPTH = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst,
  pipe_hazard_ctrl_if.slave bus
);
  localparam logic [3:0] OpLw   = 4'h8;
  localparam logic [3:0] OpSw   = 4'h9;
  localparam logic [3:0] OpB    = 4'hC;
  localparam logic [3:0] OpJr   = 4'hE;
  localparam logic [3:0] OpExec = 4'hF;

  typedef enum logic [2:0] {StRun, StBrWait, StJrWait, StExecHold, StExecRet} state_e;

  state_e                state_q, state_d;
  logic [3:0]            cond_q, cond_d;
  // Only opcode and rd of past instructions matter for hazard checks.
  logic [3:0]            hist_op_q [HIST_DEPTH];
  logic [3:0]            hist_op_d [HIST_DEPTH];
  logic [3:0]            hist_rd_q [HIST_DEPTH];
  logic [3:0]            hist_rd_d [HIST_DEPTH];
  logic [HIST_DEPTH-1:0] hist_vld_q, hist_vld_d;
  logic [CNT_W-1:0]      stall_q, stall_d, flush_q, flush_d;

  logic [3:0]            op, rd_f, rs_f, rt_f;
  logic [HIST_DEPTH-1:0] raw_mask_c;
  logic                  load_use;
  logic                  hold_c, flush_c, bubble_c, taken_c;
  logic [1:0]            sel_c;
  logic                  pc_hold_o, bubble_o, flush_o;

  assign op   = bus.instr_in[IW-1:IW-4];
  assign rd_f = bus.instr_in[IW-5:IW-8];
  assign rs_f = bus.instr_in[7:4];
  assign rt_f = bus.instr_in[3:0];

  function automatic logic writes_reg(input logic [3:0] o);
    return !(o == OpSw || o == OpB || o == OpJr || o == OpExec);
  endfunction

  // flag[0]=Z, flag[1]=V, flag[2]=N
  function automatic logic cond_taken(input logic [3:0] c, input logic [2:0] f);
    logic t;
    unique case (c)
      4'd0:    t = f[0];
      4'd1:    t = !f[0];
      4'd2:    t = !f[0] && !f[2];
      4'd3:    t = f[2];
      4'd4:    t = f[0] || !f[2];
      4'd5:    t = f[0] || f[2];
      4'd6:    t = f[1];
      default: t = 1'b0;
    endcase
    return t;
  endfunction

  always_comb begin
    raw_mask_c = '0;
    for (int i = 0; i < HIST_DEPTH; i++) begin
      if (bus.instr_valid && hist_vld_q[i] && writes_reg(hist_op_q[i]) &&
          (hist_rd_q[i] == rs_f || hist_rd_q[i] == rt_f)) begin
        raw_mask_c[i] = 1'b1;
      end
    end
  end

`ifdef HAZ_LOADUSE_EN
  assign load_use = hist_vld_q[0] && (hist_op_q[0] == OpLw) && raw_mask_c[0];
`else
  assign load_use = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    cond_d   = cond_q;
    hold_c   = 1'b0;
    sel_c    = 2'b00;
    flush_c  = 1'b0;
    bubble_c = 1'b0;
    taken_c  = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus.instr_valid) begin
          if (load_use) begin
            hold_c   = 1'b1;
            bubble_c = 1'b1;
          end else if (op == OpB) begin
            // Previous ALU op is still writing flags: wait one cycle for them.
            if (hist_vld_q[0] && !hist_op_q[0][3]) begin
              hold_c  = 1'b1;
              cond_d  = rd_f;
              state_d = StBrWait;
            end else if (cond_taken(rd_f, bus.flag)) begin
              sel_c   = 2'b01;
              flush_c = 1'b1;
              taken_c = 1'b1;
            end
          end else if (op == OpJr) begin
            state_d = StJrWait;
          end else if (op == OpExec) begin
            sel_c   = 2'b11;
            flush_c = 1'b1;
            state_d = StExecHold;
          end
        end
      end
      StBrWait: begin
        if (cond_taken(cond_q, bus.flag)) begin
          sel_c   = 2'b01;
          flush_c = 1'b1;
          taken_c = 1'b1;
        end
        state_d = StRun;
      end
      StJrWait: begin
        sel_c   = 2'b10;
        flush_c = 1'b1;
        state_d = StRun;
      end
      StExecHold: begin
        hold_c  = 1'b1;
        state_d = StExecRet;
      end
      StExecRet: state_d = StRun;
      default:   state_d = StRun;
    endcase
  end

  // Outputs are forced low while reset is asserted, independent of instr_in/flag.
  assign pc_hold_o    = hold_c & ~rst;
  assign bubble_o     = bubble_c & ~rst;
  assign flush_o      = flush_c & ~rst;
  assign bus.pc_hold  = pc_hold_o;
  assign bus.bubble   = bubble_o;
  assign bus.flush    = flush_o;
  assign bus.pc_sel   = rst ? 2'b00 : sel_c;
  assign bus.br_taken = taken_c & ~rst;
  assign bus.raw_mask = rst ? '0 : raw_mask_c;
  assign bus.stall_cnt = stall_q;
  assign bus.flush_cnt = flush_q;

  always_comb begin
    hist_op_d[0] = op;
    hist_rd_d[0] = rd_f;
    for (int i = 1; i < HIST_DEPTH; i++) begin
      hist_op_d[i] = hist_op_q[i-1];
      hist_rd_d[i] = hist_rd_q[i-1];
    end
    hist_vld_d = {hist_vld_q[HIST_DEPTH-2:0], bus.instr_valid & ~pc_hold_o & ~bubble_o};
    stall_d    = (pc_hold_o && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    flush_d    = (flush_o && flush_q != '1) ? flush_q + 1'b1 : flush_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StRun;
      cond_q     <= '0;
      hist_vld_q <= '0;
      stall_q    <= '0;
      flush_q    <= '0;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_op_q[i] <= '0;
        hist_rd_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cond_q     <= cond_d;
      hist_vld_q <= hist_vld_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
      for (int i = 0; i < HIST_DEPTH; i++) begin
        hist_op_q[i] <= hist_op_d[i];
        hist_rd_q[i] <= hist_rd_d[i];
      end
    end
  end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Randomised and directed checks of pipe_hazard_ctrl against a schedule-queue reference model.
module tb_pipe_hazard_ctrl;
  localparam int unsigned IW = 16;
  localparam int unsigned HD = 4;
  localparam int unsigned CW = 4;
`ifdef HAZ_LOADUSE_EN
  localparam bit LU = 1'b1;
`else
  localparam bit LU = 1'b0;
`endif
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.IW(IW), .HIST_DEPTH(HD), .CNT_W(CW)) bus ();

  pipe_hazard_ctrl #(.IW(IW), .HIST_DEPTH(HD), .CNT_W(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Each pending entry describes the control outputs of one future cycle.
  typedef struct {bit hold; bit [1:0] sel; bit fl; bit br;} act_t;
  act_t       pend[$];
  bit [3:0]   m_cond;
  bit [15:0]  m_hi [1:HD];
  bit         m_hv [1:HD];
  int         m_stall, m_flush;
  int         total, bad;
  logic       o_hold, o_fl, o_tk, o_bub;
  logic [1:0] o_sel;
  logic [HD-1:0] o_mask;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic bit [15:0] mk(input int op, input int rd, input int rs, input int rt);
    return {op[3:0], rd[3:0], rs[3:0], rt[3:0]};
  endfunction

  function automatic bit br_ok(input bit [3:0] c, input bit [2:0] f);
    bit z = f[0], v = f[1], n = f[2];
    case (c)
      4'd0: return z;
      4'd1: return !z;
      4'd2: return !z && !n;
      4'd3: return n;
      4'd4: return z || !n;
      4'd5: return z || n;
      4'd6: return v;
      default: return 1'b0;
    endcase
  endfunction

  function automatic bit wr(input bit [3:0] op);
    return !(op == 4'h9 || op == 4'hC || op == 4'hE || op == 4'hF);
  endfunction

  task automatic step(input bit r, input bit v, input bit [15:0] ins, input bit [2:0] f);
    bit e_hold = 0, e_bub = 0, e_fl = 0, e_tk = 0, lu = 0;
    bit [1:0] e_sel = 0;
    bit [HD-1:0] e_mask = '0;
    bit [3:0] op = ins[15:12];
    bit [3:0] ncond = m_cond;
    act_t nw[$];
    act_t a;
    rst = r; bus.instr_valid = v; bus.instr_in = ins; bus.flag = f;
    #1;
    for (int i = 1; i <= HD; i++)
      if (v && m_hv[i] && wr(m_hi[i][15:12]) &&
          (m_hi[i][11:8] == ins[7:4] || m_hi[i][11:8] == ins[3:0])) e_mask[i-1] = 1'b1;
    if (pend.size() > 0) begin
      a = pend[0];
      if (a.br) begin
        e_tk = br_ok(m_cond, f); e_sel = e_tk ? 2'b01 : 2'b00; e_fl = e_tk;
      end else begin
        e_hold = a.hold; e_sel = a.sel; e_fl = a.fl;
      end
    end else if (v) begin
      lu = LU && m_hv[1] && m_hi[1][15:12] == 4'h8 && e_mask[0];
      if (lu) begin
        e_hold = 1; e_bub = 1;
      end else if (op == 4'hC) begin
        if (m_hv[1] && m_hi[1][15:12] < 4'h8) begin
          e_hold = 1; ncond = ins[11:8]; nw.push_back('{0, 2'b00, 0, 1});
        end else if (br_ok(ins[11:8], f)) begin
          e_sel = 2'b01; e_fl = 1; e_tk = 1;
        end
      end else if (op == 4'hE) begin
        nw.push_back('{0, 2'b10, 1, 0});
      end else if (op == 4'hF) begin
        e_sel = 2'b11; e_fl = 1;
        nw.push_back('{1, 2'b00, 0, 0});
        nw.push_back('{0, 2'b00, 0, 0});
      end
    end
    if (r) begin
      e_hold = 0; e_bub = 0; e_fl = 0; e_tk = 0; e_sel = 0; e_mask = '0;
    end
    o_hold = bus.pc_hold; o_sel = bus.pc_sel; o_fl = bus.flush; o_tk = bus.br_taken;
    o_bub = bus.bubble; o_mask = bus.raw_mask;
    check_val("pc_hold", 32'(o_hold), 32'(e_hold));
    check_val("pc_sel", 32'(o_sel), 32'(e_sel));
    check_val("flush", 32'(o_fl), 32'(e_fl));
    check_val("br_taken", 32'(o_tk), 32'(e_tk));
    check_val("bubble", 32'(o_bub), 32'(e_bub));
    check_val("raw_mask", 32'(o_mask), 32'(e_mask));
    check_val("stall_cnt", 32'(bus.stall_cnt), r ? 32'd0 : 32'(m_stall));
    check_val("flush_cnt", 32'(bus.flush_cnt), r ? 32'd0 : 32'(m_flush));
    @(posedge clk);
    #1;
    if (r) begin
      pend.delete();
      for (int i = 1; i <= HD; i++) m_hv[i] = 0;
      m_stall = 0; m_flush = 0;
    end else begin
      if (pend.size() > 0) void'(pend.pop_front());
      foreach (nw[k]) pend.push_back(nw[k]);
      m_cond = ncond;
      for (int i = HD; i > 1; i--) begin
        m_hi[i] = m_hi[i-1]; m_hv[i] = m_hv[i-1];
      end
      m_hi[1] = ins; m_hv[1] = v && !e_hold && !e_bub;
      if (e_hold && m_stall < CMAX) m_stall++;
      if (e_fl && m_flush < CMAX) m_flush++;
    end
  endtask

  task automatic do_reset();
    step(1, 0, 16'h0, 3'b0);
    step(1, 1, mk(12, 0, 0, 0), 3'b001);
  endtask

  initial begin
    total = 0; bad = 0; m_stall = 0; m_flush = 0; m_cond = 0;
    for (int i = 1; i <= HD; i++) begin m_hv[i] = 0; m_hi[i] = 0; end

    // Deferred branch after an ALU op.
    do_reset();
    step(0, 0, 16'h0, 3'b000);
    check_val("rst_stall", 32'(bus.stall_cnt), 32'd0);
    step(0, 1, mk(0, 1, 2, 3), 3'b000);
    step(0, 1, mk(12, 0, 0, 0), 3'b000);
    check_val("dbr_hold", 32'(o_hold), 32'd1);
    step(0, 1, mk(12, 0, 0, 0), 3'b001);
    check_val("dbr_sel", 32'(o_sel), 32'd1);
    check_val("dbr_taken", 32'(o_tk), 32'd1);
    check_val("dbr_stall", 32'(bus.stall_cnt), 32'd1);
    check_val("dbr_flush", 32'(bus.flush_cnt), 32'd1);

    // LW then BNE resolves immediately.
    do_reset();
    step(0, 1, mk(8, 3, 0, 0), 3'b000);
    step(0, 1, mk(12, 1, 0, 0), 3'b001);
    check_val("lwbne_sel", 32'(o_sel), 32'd0);
    check_val("lwbne_hold", 32'(o_hold), 32'd0);

    // Load-use.
    do_reset();
    step(0, 1, mk(8, 3, 0, 0), 3'b000);
    step(0, 1, mk(0, 4, 3, 2), 3'b000);
    check_val("lu_mask0", 32'(o_mask[0]), 32'd1);
    check_val("lu_hold", 32'(o_hold), 32'(LU));
    check_val("lu_bubble", 32'(o_bub), 32'(LU));
    step(0, 1, mk(0, 4, 3, 2), 3'b000);
    check_val("lu_reissue", 32'(o_hold), 32'd0);

    // EXEC sequence.
    do_reset();
    step(0, 1, mk(15, 0, 0, 0), 3'b000);
    check_val("ex_sel", 32'(o_sel), 32'd3);
    step(0, 1, mk(0, 1, 1, 1), 3'b000);
    check_val("ex_hold", 32'(o_hold), 32'd1);
    step(0, 1, mk(12, 0, 0, 0), 3'b001);
    check_val("ex_ret_sel", 32'(o_sel), 32'd0);
    check_val("ex_flush", 32'(bus.flush_cnt), 32'd1);
    check_val("ex_stall", 32'(bus.stall_cnt), 32'd1);

    // Reset while waiting on a deferred branch.
    do_reset();
    step(0, 1, mk(0, 1, 2, 3), 3'b000);
    step(0, 1, mk(12, 0, 0, 0), 3'b001);
    step(1, 1, mk(12, 0, 0, 0), 3'b001);
    check_val("rstbr_sel", 32'(o_sel), 32'd0);
    step(0, 0, 16'h0, 3'b001);
    check_val("rstbr_taken", 32'(o_tk), 32'd0);
    check_val("rstbr_cnt", 32'(bus.stall_cnt + bus.flush_cnt), 32'd0);

    // Counter saturation: 21 back-to-back EXEC sequences.
    do_reset();
    for (int i = 0; i < 63; i++) step(0, 1, mk(15, 0, 0, 0), 3'b000);
    check_val("sat_stall", 32'(bus.stall_cnt), 32'(CMAX));
    check_val("sat_flush", 32'(bus.flush_cnt), 32'(CMAX));

    // Random traffic.
    do_reset();
    for (int n = 0; n < 2000; n++) begin
      step($urandom_range(0, 149) == 0, $urandom_range(0, 7) != 0,
           mk($urandom_range(0, 15), $urandom_range(0, 3), $urandom_range(0, 3),
              $urandom_range(0, 3)), 3'($urandom_range(0, 7)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised pipeline hazard and branch-resolution controller for the 16-bit CPU, sitting beside the decode-stage control unit. It keeps a configurable-depth history of issued instructions and resolves conditional branches, including a one-cycle deferral when the previous instruction is still writing flags. It also sequences JR and EXEC redirects, inserts load-use bubbles, exports a per-entry RAW hazard mask for forwarding, and keeps saturating stall and flush counters.

## Interface
- IW, 16: instruction width; opcode is [IW-1:IW-4], rd/cond is [IW-5:IW-8], rs is [7:4], rt is [3:0].
- HIST_DEPTH, 4: number of history entries hist[1..HIST_DEPTH]; legal values are 2 to 8.
- CNT_W, 16: width of the performance counters.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_in  in  IW  instruction currently in decode.
- instr_valid  in  1  instr_in is a real instruction.
- flag  in  3  ALU flags: [0]=Z, [1]=V, [2]=N.
- pc_hold  out  1  freeze PC and decode register.
- pc_sel  out  2  next-PC source: 00 sequential, 01 branch target, 10 register (JR), 11 EXEC target.
- flush  out  1  kill the instruction in fetch.
- bubble  out  1  inject a NOP into execute.
- br_taken  out  1  branch resolved taken this cycle.
- raw_mask  out  HIST_DEPTH  bit i-1 is set when hist[i] hazards against instr_in.
- stall_cnt, flush_cnt  out  CNT_W  saturating counters.

## Operation
- Opcode map:
  - 0–7: ALU operations (bit 15 = 0), which write flags.
  - 8 LW, 9 SW, A LHB, B LLB, C B, D JAL, E JR, F EXEC.
- History:
  - On each clock edge, hist[1] takes instr_in with its valid bit equal to instr_valid & ~pc_hold & ~bubble.
  - hist[k] takes hist[k-1].
  - Any held or bubbled cycle shifts in an invalid entry.
- raw_mask[i-1] is set when all of the following hold:
  - hist[i] is valid;
  - hist[i] writes a register (opcode not SW, B, JR or EXEC);
  - hist[i] rd equals instr_in rs or rt.
  - raw_mask is purely combinational and is 0 when instr_valid=0.
- Branch condition codes (cond field): 0 BEQ (Z), 1 BNE (!Z), 2 BGT (!Z&!N), 3 BLT (N), 4 BGE (Z|!N), 5 BLE (Z|N), 6 BOF (V). Codes 7–15 are never taken.
- FSM states: RUN, BR_WAIT, JR_WAIT, EXEC_HOLD, EXEC_RET. Priority in RUN: load-use > B > JR > EXEC > pass.
- RUN behaviour:
  - instr_valid=0: all outputs 0.
  - Load-use stall:
    - Trigger: `HAZ_LOADUSE_EN` is defined, hist[1] is a valid LW, and raw_mask[0]=1.
    - Response: pc_hold=1 and bubble=1; stay in RUN.
  - B with valid hist[1] opcode < 8: pc_hold=1, the cond field is latched into cond_r, go to BR_WAIT.
  - B otherwise: resolve against the current flag. If taken, pc_sel=01, flush=1, br_taken=1. Stay in RUN.
  - JR: go to JR_WAIT (no hold).
  - EXEC: pc_sel=11, flush=1, go to EXEC_HOLD.
- BR_WAIT:
  - Resolve cond_r against the current flag.
  - If taken, pc_sel=01, flush=1, br_taken=1.
  - Return to RUN unconditionally.
- JR_WAIT: pc_sel=10, flush=1, go to RUN.
- EXEC_HOLD: pc_hold=1 (the target instruction executes); go to EXEC_RET.
- EXEC_RET: pc_sel=00 (resume), go to RUN.
- Counters:
  - stall_cnt increments on every cycle with pc_hold=1.
  - flush_cnt increments on every cycle with flush=1.
  - Both saturate at all-ones and never wrap.

## Timing
- Control outputs (pc_hold, pc_sel, flush, bubble, br_taken) are combinational (Mealy) from instr_in, flag, state and history. State, history and counters are registered.
- Outputs during and immediately after reset:
  - While rst=1, every output is 0.
  - After rst deasserts: state=RUN, all history entries invalid, raw_mask=0, counters=0.
- Reset mid-operation (BR_WAIT or EXEC_*): the pending redirect is dropped; no pc_sel pulse follows.
- Latencies:
  - Deferred branch: resolves exactly 1 cycle after decode, with exactly 1 stall cycle.
  - Non-deferred branch: resolves in 0 cycles.
  - JR: redirects 1 cycle after decode.
  - EXEC: 3 cycles from decode to resume.
- The instruction in hist[1] during BR_WAIT is invalid (held shift), so back-to-back B never re-defers.
- instr_in is ignored outside RUN.

## Configuration
- `HAZ_LOADUSE_EN` defined: load-use detection and the bubble stall as described above.
- `HAZ_LOADUSE_EN` undefined: bubble is tied to 0 and no load-use hold occurs. raw_mask is still produced, for the forwarding unit.

## Test plan
- ADD r1 then BEQ with Z=1 on the second cycle → cycle 1: pc_hold=1; cycle 2: pc_sel=01, flush=1, br_taken=1; stall_cnt=1.
- LW then BNE with Z=1 → same-cycle resolution, not taken; pc_sel=00, pc_hold=0.
- LW r3 then ADD r4,r3,r2 with `HAZ_LOADUSE_EN` defined → one cycle with pc_hold=1 and bubble=1, then normal issue. Without the macro → no stall and raw_mask[0]=1.
- EXEC → pc_sel=11 with flush=1, then pc_hold=1, then pc_sel=00; flush_cnt=1, stall_cnt=1.
- Assert rst during BR_WAIT → all outputs 0 at once; after release, no branch pulse occurs and the counters read 0.
- Force 2^CNT_W + 5 stall cycles (CNT_W=4) → stall_cnt holds at 15.
